// File: rtl/instr_sequencer_if.sv
// Handshake bundle between instr_sequencer and control_unit.
// Master presents instructions; slave answers with cu_ready.
interface instr_sequencer_if;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        cu_ready;

    modport master (
        output instruction,
        output instr_valid,
        input  cu_ready
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output cu_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer feeding control_unit.
// Walks a small program memory from address 0 and halts on END.
module instr_sequencer #(
    parameter int IMEM_DEPTH     = 8,
    parameter int ADDR_W         = 3,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              imem_wr_en,
    input  logic [ADDR_W-1:0] imem_wr_addr,
    input  logic [15:0]       imem_wr_data,
    instr_sequencer_if.master cu,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [2:0] OP_END     = 3'b000;
    localparam logic [2:0] OP_COMPUTE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       imem_q [IMEM_DEPTH];

    logic [2:0] op;
    logic       is_end;
    logic       is_ill;
    logic       at_last;
    logic       wr_ok;
    logic       valid;

    assign op      = ir_q[15:13];
    assign is_end  = (op == OP_END);
    assign is_ill  = (op == 3'b110) || (op == 3'b111);
    assign at_last = (pc_q == ADDR_W'(IMEM_DEPTH - 1));
    assign wr_ok   = (state_q == S_IDLE) || (state_q == S_DONE);

    // Program memory survives reset; it is only writable while stopped.
    always_ff @(posedge clk) begin
        if (wr_ok && imem_wr_en) begin
            imem_q[imem_wr_addr] <= imem_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                unique case (1'b1)
                    is_end: state_d = S_DONE;
                    is_ill: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                    default: begin
                        if (cu.cu_ready) begin
                            if (op == OP_COMPUTE && COMPUTE_CYCLES > 1) begin
                                cnt_d   = CNT_W'(1);
                                state_d = S_HOLD;
                            end else if (at_last) begin
                                state_d = S_DONE;
                            end else begin
                                pc_d    = pc_q + 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                    end
                endcase
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend on state only; cu_ready merely moves the FSM.
    assign valid = ((state_q == S_ISSUE) && !is_end && !is_ill)
                || (state_q == S_HOLD);

    assign cu.instr_valid = valid;
    assign cu.instruction = valid ? ir_q : 16'h0000;
    assign pc    = pc_q;
    assign busy  = (state_q == S_FETCH) || (state_q == S_ISSUE)
                || (state_q == S_HOLD);
    assign done  = (state_q == S_DONE);
    assign error = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer.
// Expected traces come from a program-walk model of the sequencer.
module tb_instr_sequencer;

    localparam int CC = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_wr_en;
    logic [2:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic [2:0]  pc;
    logic        busy;
    logic        done;
    logic        error;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .IMEM_DEPTH     (8),
        .ADDR_W         (3),
        .COMPUTE_CYCLES (CC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cu           (bus.master),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [15:0] mem_m [8];
    bit          rdy_m [300];
    bit          exp_v [300];
    logic [15:0] exp_i [300];
    bit          exp_b [300];
    int          exp_pc;
    bit          exp_err;

    // Walk the program address by address and lay out, cycle by cycle,
    // what control_unit should see. Returns the cycle in which done rises.
    task automatic build_model(output int d);
        int       k;
        int       a;
        bit       fin;
        logic [15:0] w;
        logic [2:0]  op;
        k = 1;
        a = 0;
        fin = 0;
        exp_err = 0;
        while (!fin) begin
            w  = mem_m[a];
            op = w[15:13];
            exp_v[k] = 0; exp_i[k] = 0; exp_b[k] = 1; k++;
            if (op == 3'd0 || op >= 3'd6) begin
                exp_v[k] = 0; exp_i[k] = 0; exp_b[k] = 1; k++;
                exp_err = (op != 3'd0);
                fin = 1;
            end else begin
                while (!rdy_m[k]) begin
                    exp_v[k] = 1; exp_i[k] = w; exp_b[k] = 1; k++;
                end
                exp_v[k] = 1; exp_i[k] = w; exp_b[k] = 1; k++;
                if (op == 3'd4) begin
                    repeat (CC - 1) begin
                        exp_v[k] = 1; exp_i[k] = w; exp_b[k] = 1; k++;
                    end
                end
                if (a == 7) fin = 1;
                else a++;
            end
        end
        exp_pc = a;
        d = k;
        exp_v[d] = 0; exp_i[d] = 0; exp_b[d] = 0;
    endtask

    task automatic set_full_prog();
        mem_m[0] = 16'h200F; mem_m[1] = 16'h4000;
        mem_m[2] = 16'h201E; mem_m[3] = 16'h6000;
        mem_m[4] = 16'h8000; mem_m[5] = 16'h2007;
        mem_m[6] = 16'hA000; mem_m[7] = 16'h0000;
    endtask

    task automatic all_ready();
        for (int i = 0; i < 300; i++) rdy_m[i] = 1;
    endtask

    task automatic load_mem();
        for (int a = 0; a < 8; a++) begin
            imem_wr_en   = 1;
            imem_wr_addr = 3'(a);
            imem_wr_data = mem_m[a];
            @(posedge clk); #1;
        end
        imem_wr_en = 0;
    endtask

    // Optionally loads the program (last word written in the start cycle),
    // starts it, and compares every cycle up to done against the model.
    task automatic run_prog(input bit do_load, input string tag,
                            output int dcyc);
        int d;
        build_model(d);
        if (do_load) begin
            for (int a = 0; a < 7; a++) begin
                imem_wr_en   = 1;
                imem_wr_addr = 3'(a);
                imem_wr_data = mem_m[a];
                @(posedge clk); #1;
            end
            imem_wr_en   = 1;
            imem_wr_addr = 3'd7;
            imem_wr_data = mem_m[7];
        end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        imem_wr_en = 0;
        bus.cu_ready = rdy_m[1];
        dcyc = 0;
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== exp_v[k]) begin
                errors++;
                $display("FAIL %s cyc%0d valid got %b exp %b",
                         tag, k, bus.instr_valid, exp_v[k]);
            end
            checks++;
            if (bus.instruction !== exp_i[k]) begin
                errors++;
                $display("FAIL %s cyc%0d instr got %h exp %h",
                         tag, k, bus.instruction, exp_i[k]);
            end
            checks++;
            if (busy !== exp_b[k]) begin
                errors++;
                $display("FAIL %s cyc%0d busy got %b exp %b",
                         tag, k, busy, exp_b[k]);
            end
            checks++;
            if (done !== (k == d)) begin
                errors++;
                $display("FAIL %s cyc%0d done got %b exp %b",
                         tag, k, done, (k == d));
            end
            checks++;
            if (error !== ((k == d) ? exp_err : 1'b0)) begin
                errors++;
                $display("FAIL %s cyc%0d error got %b exp %b",
                         tag, k, error, ((k == d) ? exp_err : 1'b0));
            end
            if (k == d) begin
                checks++;
                if (pc !== 3'(exp_pc)) begin
                    errors++;
                    $display("FAIL %s pc got %0d exp %0d", tag, pc, exp_pc);
                end
            end
            if (done === 1'b1 && dcyc == 0) dcyc = k;
            @(posedge clk); #1;
            bus.cu_ready = rdy_m[k + 1];
        end
        bus.cu_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.instruction, bus.instr_valid, pc, busy, done, error}
                !== 25'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d outputs got %h exp 0",
                         i, {bus.instruction, bus.instr_valid, pc,
                             busy, done, error});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_program();
        int dc;
        set_full_prog();
        all_ready();
        run_prog(1, "full", dc);
        checks++;
        if (dc !== 22) begin
            errors++;
            $display("FAIL full done_cycle got %0d exp 22", dc);
        end
        checks++;
        if ({pc, error} !== {3'd7, 1'b0}) begin
            errors++;
            $display("FAIL full pc/err got %0d/%b exp 7/0", pc, error);
        end
    endtask

    task automatic test_backpressure();
        int dc;
        set_full_prog();
        all_ready();
        rdy_m[4] = 0; rdy_m[5] = 0; rdy_m[6] = 0;
        run_prog(0, "bp", dc);
        checks++;
        if (dc !== 25) begin
            errors++;
            $display("FAIL bp done_cycle got %0d exp 25", dc);
        end
    endtask

    task automatic test_illegal_restart();
        int dc;
        set_full_prog();
        mem_m[2] = 16'hC000;
        all_ready();
        run_prog(1, "illegal", dc);
        checks++;
        if ({done, error, pc} !== {1'b1, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL illegal done/err/pc got %b/%b/%0d exp 1/1/2",
                     done, error, pc);
        end
        imem_wr_en   = 1;
        imem_wr_addr = 3'd2;
        imem_wr_data = 16'h0000;
        @(posedge clk); #1;
        imem_wr_en = 0;
        mem_m[2] = 16'h0000;
        run_prog(0, "restart", dc);
        checks++;
        if ({done, error, pc} !== {1'b1, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL restart done/err/pc got %b/%b/%0d exp 1/0/2",
                     done, error, pc);
        end
    endtask

    task automatic test_no_end();
        int dc;
        for (int a = 0; a < 8; a++) mem_m[a] = 16'h2001;
        all_ready();
        run_prog(1, "noend", dc);
        checks++;
        if ({done, error, pc, dc} !== {1'b1, 1'b0, 3'd7, 32'd17}) begin
            errors++;
            $display("FAIL noend done/err/pc/cyc got %b/%b/%0d/%0d exp 1/0/7/17",
                     done, error, pc, dc);
        end
    endtask

    task automatic test_reset_hold_lockout();
        int dc;
        set_full_prog();
        all_ready();
        load_mem();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({bus.instr_valid, bus.instruction} !== {1'b1, 16'h8000}) begin
            errors++;
            $display("FAIL hold3 valid/instr got %b/%h exp 1/8000",
                     bus.instr_valid, bus.instruction);
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checks++;
        if ({bus.instruction, bus.instr_valid, pc, busy, done, error}
            !== 25'd0) begin
            errors++;
            $display("FAIL midreset outputs got %h exp 0",
                     {bus.instruction, bus.instr_valid, pc, busy, done, error});
        end
        @(posedge clk); #1;
        run_prog(0, "rerun", dc);
        checks++;
        if (dc !== 22) begin
            errors++;
            $display("FAIL rerun done_cycle got %0d exp 22", dc);
        end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 5; i++) begin
            imem_wr_en   = 1;
            imem_wr_addr = 3'(i);
            imem_wr_data = 16'hE000;
            @(posedge clk); #1;
        end
        imem_wr_en = 0;
        for (int i = 0; i < 60 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL lockout_run done got %b exp 1 (timeout)", done);
        end
        run_prog(0, "lockout", dc);
    endtask

    task automatic test_random();
        int dc;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 8; a++) begin
                mem_m[a] = 16'($urandom);
                if ($urandom_range(0, 3) != 0)
                    mem_m[a][15:13] = 3'($urandom_range(1, 5));
            end
            for (int i = 0; i < 300; i++)
                rdy_m[i] = (i % 4 == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            run_prog(1, $sformatf("rand%0d", it), dc);
        end
    endtask

    initial begin
        clk          = 0;
        reset        = 1;
        start        = 0;
        imem_wr_en   = 0;
        imem_wr_addr = '0;
        imem_wr_data = '0;
        bus.cu_ready = 1;
        checks       = 0;
        errors       = 0;
        test_reset();
        test_full_program();
        test_backpressure();
        test_illegal_restart();
        test_no_end();
        test_reset_hold_lockout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
